// File: rtl/vga_frame_reader.sv
// Read side of the camera frame buffer: scans the 160x120 RGB444 BRAM and
// drives a 640x480@60 VGA display, with each stored pixel shown as a 4x4 block.
module vga_frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SRC_W    = 160
) (
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        enable,
   output logic [18:0] rd_addr,
   input  logic [11:0] rd_data,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [18:0]   STRIDE = 19'(SRC_W);

   // stage 0: raster position and the frame-buffer row it maps to
   logic [HW-1:0] hcount, h_nxt;
   logic [VW-1:0] vcount, v_nxt;
   logic [18:0]   row_base, base_nxt, addr_nxt;
   logic          act_nxt;

   always_comb begin
      h_nxt    = hcount + 1'b1;
      v_nxt    = vcount;
      base_nxt = row_base;
      if (hcount == H_LAST) begin
         h_nxt = '0;
         v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
         if (v_nxt == '0)
            base_nxt = '0;
         else if (v_nxt[1:0] == 2'b00)
            base_nxt = row_base + STRIDE;
      end
   end

   // The BRAM needs a full cycle to return data, so the address register is
   // loaded from the next raster position: rd_addr always tracks the current
   // hcount/vcount and the colour lands on the pins with the delayed sync.
   always_comb begin
      act_nxt  = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      addr_nxt = act_nxt ? base_nxt + 19'(h_nxt >> 2) : rd_addr;
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         hcount   <= '0;
         vcount   <= '0;
         row_base <= '0;
         rd_addr  <= '0;
      end else begin
         hcount   <= h_nxt;
         vcount   <= v_nxt;
         row_base <= base_nxt;
         rd_addr  <= addr_nxt;
      end
   end

   logic act0, hs0, vs0, first0;

   always_comb begin
      act0   = (hcount < H_ACT) && (vcount < V_ACT);
      hs0    = !((hcount >= HS_BEG) && (hcount < HS_END));
      vs0    = !((vcount >= VS_BEG) && (vcount < VS_END));
      first0 = (hcount == '0) && (vcount == '0);
   end

   // stage 1 flags, then stage 2 output registers alongside rd_data
   logic act_d1, hs_d1, vs_d1, first_d1;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         act_d1                <= 1'b0;
         hs_d1                 <= 1'b1;
         vs_d1                 <= 1'b1;
         first_d1              <= 1'b0;
         vga_hs                <= 1'b1;
         vga_vs                <= 1'b1;
         frame_start           <= 1'b0;
         {vga_r, vga_g, vga_b} <= 12'h000;
      end else begin
         act_d1                <= act0;
         hs_d1                 <= hs0;
         vs_d1                 <= vs0;
         first_d1              <= first0;
         vga_hs                <= hs_d1;
         vga_vs                <= vs_d1;
         frame_start           <= first_d1;
         {vga_r, vga_g, vga_b} <= (act_d1 && enable) ? rd_data : 12'h000;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Random-image, random-enable bench for vga_frame_reader on a reduced raster,
// checked every cycle against a position-based reference model.
module tb_vga_frame_reader;

   localparam int HA = 64, HF = 8, HS = 16, HB = 8;
   localparam int VA = 32, VF = 3, VS = 2,  VB = 4;
   localparam int SW = 16;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam int NMEM = (VA / 4) * SW;

   logic        pclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b1;
   logic [18:0] rd_addr;
   logic [11:0] rd_data;
   logic        vga_hs, vga_vs, frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;

   logic [11:0] mem [NMEM];
   int n_cmp = 0;
   int n_err = 0;
   int t, vs_fall_t, fs_cnt, vs_low, drop_left;
   logic prev_vs;

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SRC_W(SW)
   ) dut (
      .pclk(pclk), .reset_n(reset_n), .enable(enable),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   always #20 pclk = ~pclk;

   // synchronous-read BRAM, port B
   always @(posedge pclk)
      rd_data <= (rd_addr < 19'(NMEM)) ? mem[rd_addr[6:0]] : 12'hBAD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, obs, exp);
      end
   endtask

   function automatic int addr_of(input int x, input int y);
      return (y / 4) * SW + x / 4;
   endfunction

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_hs"},   32'(vga_hs), 32'd1);
      chk({pfx, "_vs"},   32'(vga_vs), 32'd1);
      chk({pfx, "_rgb"},  32'({vga_r, vga_g, vga_b}), 32'd0);
      chk({pfx, "_fs"},   32'(frame_start), 32'd0);
      chk({pfx, "_addr"}, 32'(rd_addr), 32'd0);
   endtask

   // t = pclk edges since reset release; pins show raster position t-2,
   // rd_addr reflects position t (held at the last visible pixel in blanking)
   task automatic check_cycle();
      int p, x, y, p0, x0, y0, ea;
      logic ehs, evs, efs;
      logic [11:0] ecol;
      if (t < 2) begin
         ehs = 1'b1; evs = 1'b1; efs = 1'b0; ecol = 12'h000;
      end else begin
         p = (t - 2) % FR;
         x = p % HT;
         y = p / HT;
         ehs  = !(x >= HA + HF && x < HA + HF + HS);
         evs  = !(y >= VA + VF && y < VA + VF + VS);
         efs  = (p == 0);
         ecol = (x < HA && y < VA && enable) ? mem[addr_of(x, y)] : 12'h000;
      end
      p0 = t % FR;
      x0 = p0 % HT;
      y0 = p0 / HT;
      if (y0 >= VA)      ea = addr_of(HA - 1, VA - 1);
      else if (x0 >= HA) ea = addr_of(HA - 1, y0);
      else               ea = addr_of(x0, y0);
      chk("hs",   32'(vga_hs), 32'(ehs));
      chk("vs",   32'(vga_vs), 32'(evs));
      chk("fs",   32'(frame_start), 32'(efs));
      chk("rgb",  32'({vga_r, vga_g, vga_b}), 32'(ecol));
      chk("addr", 32'(rd_addr), 32'(ea));
   endtask

   // enable for the coming edge: a fixed 20-pixel blank on line 10 plus random drops
   task automatic set_enable();
      int q;
      logic directed;
      q = t - 1;
      directed = 1'b0;
      if (q >= 0)
         directed = ((q % FR) >= 10 * HT + 20) && ((q % FR) < 10 * HT + 40);
      if (drop_left > 0)
         drop_left--;
      else if ($urandom_range(0, 499) == 0)
         drop_left = $urandom_range(1, 30);
      enable = !(directed || drop_left > 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pclk);
         t++;
         @(negedge pclk);
         check_cycle();
         if (prev_vs && !vga_vs && vs_fall_t < 0) vs_fall_t = t;
         prev_vs = vga_vs;
         if (frame_start) fs_cnt++;
         if (!vga_vs) vs_low++;
         set_enable();
      end
   endtask

   task automatic release_reset();
      @(negedge pclk);
      reset_n   = 1'b1;
      t         = 0;
      vs_fall_t = -1;
      fs_cnt    = 0;
      vs_low    = 0;
      prev_vs   = 1'b1;
      drop_left = 0;
      set_enable();
   endtask

   initial begin
      for (int i = 0; i < NMEM; i++) mem[i] = 12'($urandom_range(1, 4095));
      mem[0] = 12'hFFF;
      t = 0;
      reset_n = 1'b0;
      enable  = 1'b1;
      repeat (3) @(negedge pclk);
      chk_reset_vals("rst");

      release_reset();
      run(3 * FR + 20 * HT + 30);
      chk("vs_fall_first", 32'(vs_fall_t), 32'((VA + VF) * HT + 2));
      chk("fs_count_a", 32'(fs_cnt), 32'd4);

      // asynchronous reset in the middle of line 20, pixel 30
      #5 reset_n = 1'b0;
      #1 chk_reset_vals("arst");
      repeat (2) @(negedge pclk);
      chk_reset_vals("arst_hold");

      release_reset();
      run(2 * FR + 100);
      chk("vs_fall_restart", 32'(vs_fall_t), 32'((VA + VF) * HT + 2));
      chk("fs_count_b", 32'(fs_cnt), 32'd3);
      chk("vs_low_cycles", 32'(vs_low), 32'(2 * VS * HT));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
